// File: rtl/xor_stream_ctrl.sv
// rtl/xor_stream_ctrl.sv - sequencing controller for the byte-wide XOR encrypter
// Drives key/shift/data into a 2-stage encrypter, tracks in-flight bytes, buffers results in a FWFT FIFO.
module xor_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_key,
  input  logic [2:0] cfg_shift,
  input  logic [2:0] cfg_step,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic [7:0] enc_key,
  output logic [2:0] enc_shift,
  output logic [7:0] enc_din,
  input  logic [7:0] enc_dout,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  logic [7:0]    key_r;
  logic [2:0]    cur_shift;
  logic [2:0]    step_r;
  logic [7:0]    din_r;
  logic          tag0_v, tag0_last;
  logic          tag1_v, tag1_last;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic [CNT_W:0] inflight;
  logic          accept, cfg_fire, push, pop, full;

  // Credit counts bytes already in the FIFO plus those still inside the encrypter,
  // so a byte is only accepted when a FIFO slot is guaranteed on arrival.
  assign inflight  = {1'b0, count} + (CNT_W+1)'(tag0_v) + (CNT_W+1)'(tag1_v);
  assign cfg_ready = (state == IDLE);
  assign s_ready   = (state == RUN) && (inflight < (CNT_W+1)'(FIFO_DEPTH));
  assign accept    = s_valid && s_ready;
  assign cfg_fire  = cfg_valid && cfg_ready;

  assign enc_key   = key_r;
  assign enc_shift = cur_shift;
  assign enc_din   = din_r;

  assign push    = tag1_v;
  assign pop     = m_valid && m_ready;
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr][7:0];
  assign m_last  = mem[rd_ptr][8];
  assign busy    = (state != IDLE) || (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_r     <= '0;
      cur_shift <= '0;
      step_r    <= '0;
      din_r     <= '0;
      tag0_v    <= 1'b0;
      tag0_last <= 1'b0;
      tag1_v    <= 1'b0;
      tag1_last <= 1'b0;
    end else begin
      tag1_v    <= tag0_v;
      tag1_last <= tag0_last;
      tag0_v    <= accept;
      tag0_last <= accept && s_last;
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            key_r     <= cfg_key;
            cur_shift <= cfg_shift;
            step_r    <= cfg_step;
            state     <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            din_r     <= s_data;
            cur_shift <= cur_shift + step_r;
            if (s_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!tag0_v && !tag1_v) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result of the byte tagged in tag1 is on enc_dout this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {tag1_last, enc_dout};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);

endmodule
